// File: rtl/regs_pkg.sv
// ============================================================================
// Module   : regs_pkg
// Brief    : Shared constants and write-back request type for the integer
//            register file write-back path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regs_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Register x0 is hard-wired to zero; writes to it are dropped.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regs_wb_fifo.sv
// ============================================================================
// Module   : regs_wb_fifo
// Brief    : DEPTH-entry in-order FIFO of write-back requests. Exposes a
//            per-entry valid bit and address so the parent can detect pending
//            writes to a source register without popping.
//            DEPTH must be a power of two (pointers wrap by overflow).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regs_wb_fifo
    import regs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wb_req_t                              push_req,
    input  logic                                 pop,
    output wb_req_t                              head,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH):0]               count,
    output logic [DEPTH-1:0]                     ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_vld;

    // Entry storage; contents are only observed through r_vld, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_req;
        end
    end

    // Read/write pointers and occupancy; simultaneous push+pop keeps count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-entry occupancy flags. Push never targets the popped slot because
    // push requires not-full and pop requires not-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            if (pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (push) begin
                r_vld[r_wr_ptr] <= 1'b1;
            end
        end
    end

    assign head    = r_mem[r_rd_ptr];
    assign full    = (r_count == c_cnt_full);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign ent_vld = r_vld;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign ent_addr[gi] = r_mem[gi].addr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/regs_wb.sv
// ============================================================================
// Module   : regs_wb
// Brief    : Register-file write-back stage. Arbitrates execute and load
//            write requests (load first), drops writes to x0, buffers the rest
//            in order and issues one registered write per cycle to storage.
//            Provides rs1/rs2 busy flags for decode stalls.
//            Optional feature macro: REGS_WB_BYPASS_EN -- an accepted write
//            into an idle buffer goes straight to the output register.
//            ADDR_W/DATA_W must match REG_ADDR_W/XLEN of regs_pkg.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regs_wb
    import regs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic [DATA_W-1:0] ex_rd_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              wb_hold,
    output logic              rd_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy
);

`ifdef REGS_WB_BYPASS_EN
    localparam bit c_bypass_en = 1'b1;
`else
    localparam bit c_bypass_en = 1'b0;
`endif

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                              w_full;
    logic                              w_empty;
    logic [CNT_W-1:0]                  w_count;
    logic [DEPTH-1:0]                  w_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  w_ent_addr;
    wb_req_t                           w_head;
    wb_req_t                           w_push_req;

    logic              w_mem_fire;
    logic              w_ex_fire;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_live;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_rs1_hit;
    logic              w_rs2_hit;

    // Readiness is forced low while reset is asserted. The load path wins
    // because it carries the older instruction.
    assign mem_ready = rst && !w_full;
    assign ex_ready  = rst && !w_full && !mem_valid;

    assign w_mem_fire = mem_valid && mem_ready;
    assign w_ex_fire  = ex_valid  && ex_ready;
    assign w_accept   = w_mem_fire || w_ex_fire;
    assign w_sel_addr = w_mem_fire ? mem_rd_addr : ex_rd_addr;
    assign w_sel_data = w_mem_fire ? mem_rd_data : ex_rd_data;

    // x0 writes complete the handshake but are otherwise discarded.
    assign w_live = w_accept && (w_sel_addr != REG_ZERO);

    assign w_pop = !w_empty && !wb_hold;

    // Bypass only when nothing is buffered (so ordering is trivially kept)
    // and the storage port is free this cycle.
    assign w_bypass = c_bypass_en && w_live && (w_count == '0) && !wb_hold;
    assign w_push   = w_live && !w_bypass;

    assign w_push_req.addr = w_sel_addr;
    assign w_push_req.data = w_sel_data;

    regs_wb_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_req (w_push_req),
        .pop      (w_pop),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .ent_vld  (w_vld),
        .ent_addr (w_ent_addr)
    );

    // Output write register: head of buffer, else bypassed request, else idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_we   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (w_pop) begin
            rd_we   <= 1'b1;
            rd_addr <= w_head.addr;
            rd_data <= w_head.data;
        end else if (w_bypass) begin
            rd_we   <= 1'b1;
            rd_addr <= w_sel_addr;
            rd_data <= w_sel_data;
        end else begin
            rd_we   <= 1'b0;
        end
    end

    // Pending-write match against buffered entries and the in-flight write.
    always_comb begin
        w_rs1_hit = rd_we && (rd_addr == rs1_addr);
        w_rs2_hit = rd_we && (rd_addr == rs2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i] && (w_ent_addr[i] == rs1_addr)) begin
                w_rs1_hit = 1'b1;
            end
            if (w_vld[i] && (w_ent_addr[i] == rs2_addr)) begin
                w_rs2_hit = 1'b1;
            end
        end
    end

    assign rs1_busy = (rs1_addr != REG_ZERO) && w_rs1_hit;
    assign rs2_busy = (rs2_addr != REG_ZERO) && w_rs2_hit;

endmodule

`default_nettype wire
